// File: rtl/vga_pkg.sv
// Shared raster timing defaults, pixel/coordinate types and the RGB332 colour
// expansion used by the VGA sink.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_MUX_LAT  = 1;
    localparam bit DEF_SYNC_POL = 1'b0;

    typedef logic [10:0] coord_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Replicate the top bits so full-scale codes reach 0xF on the 4-bit DAC.
    function automatic logic [11:0] expand332(rgb332_t c);
        return {c.r, c.r[2], c.g, c.g[2], c.b, c.b};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset; DEPTH = 0 is a wire.
// Used to line sync and blank up with the colour coming back from the mux.
module vga_delay_line #(
    parameter int                WIDTH     = 3,
    parameter int                DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            // NOTE: every stage is reset, not just the last one, so a sync
            // pulse captured before reset can never emerge after release.
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_frame_driver.sv
// VGA sink: raster counters, sync/blank aligned to the objects_mux latency,
// RGB332 -> 4:4:4 expansion at the pins, and a once-per-frame tick.
module vga_frame_driver
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int MUX_LAT  = DEF_MUX_LAT,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  rgbIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        displayActive,
    output logic        frameTick,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB,
    output logic        vgaHS,
    output logic        vgaVS
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t h_count;
    coord_t v_count;
    logic   h_sync_raw;
    logic   v_sync_raw;
    logic   hs_d;
    logic   vs_d;
    logic   active_d;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, which keeps the h/v wrap on the same edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_count   <= '0;
            v_count   <= '0;
            frameTick <= 1'b0;
        end else begin
            frameTick <= (h_count == '0) && (v_count == V_ACT_END);
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    assign pixelX        = h_count;
    assign pixelY        = v_count;
    assign displayActive = (h_count < H_ACT_END) && (v_count < V_ACT_END);
    assign h_sync_raw    = (h_count >= HS_START) && (h_count < HS_END);
    assign v_sync_raw    = (v_count >= VS_START) && (v_count < VS_END);

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (MUX_LAT),
        .RESET_VAL (3'b000)
    ) u_align (
        .clk    (clk),
        .resetN (resetN),
        .din    ({h_sync_raw, v_sync_raw, displayActive}),
        .dout   ({hs_d, vs_d, active_d})
    );

    // Colour, sync and blank are registered together so they hit the pins on
    // the same edge, MUX_LAT+1 clocks after the coordinate that produced them.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vgaR  <= '0;
            vgaG  <= '0;
            vgaB  <= '0;
            vgaHS <= ~SYNC_POL;
            vgaVS <= ~SYNC_POL;
        end else begin
            vgaHS <= hs_d ? SYNC_POL : ~SYNC_POL;
            vgaVS <= vs_d ? SYNC_POL : ~SYNC_POL;
            {vgaR, vgaG, vgaB} <= active_d ? expand332(rgb332_t'(rgbIn)) : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_frame_driver.sv
// Scoreboard bench for vga_frame_driver: several timing/latency/polarity
// configurations, each with its own mux model, raster model and reset schedule.
module tb_vga_frame_driver;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
    } pins_t;

    typedef struct packed {
        int ha; int hf; int hsw; int hb;
        int va; int vf; int vsw; int vb;
        int ml;
        int mode;   // 0: colour = x[7:0], 1: constant 0xFF, 2: seeded hash of (x,y)
        bit sp;
    } cfg_t;

    localparam int NCFG = 5;

    function automatic cfg_t cfg_of(int k);
        cfg_t c;
        c = '{ha: 16, hf: 4, hsw: 6, hb: 4, va: 10, vf: 2, vsw: 2, vb: 3,
              ml: 0, mode: 1, sp: 1'b0};
        case (k)
            0: c = '{ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33,
                     ml: 1, mode: 0, sp: 1'b0};
            1: begin c.ml = 0; c.mode = 1; c.sp = 1'b0; end
            2: begin c.ml = 3; c.mode = 2; c.sp = 1'b1; end
            3: begin c.ml = 3; c.mode = 1; c.sp = 1'b0; end
            default: begin c.ml = 2; c.mode = 2; c.sp = 1'b0; end
        endcase
        return c;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(string what, int k, int n, int actual, int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL cfg%0d %s at cycle %0d: got %0d expected %0d",
                     k, what, n, actual, expected);
        end
    endtask

    // Colour the mux would produce for pixel (x, y).
    function automatic logic [7:0] pat(int mode, int x, int y, int unsigned s1, int unsigned s2);
        int unsigned h;
        h = (int'(x) * s1) ^ (int'(y) * s2) ^ (s1 >> 7);
        case (mode)
            0:       return 8'(x % 256);
            1:       return 8'hFF;
            default: return h[7:0];
        endcase
    endfunction

    // Pins expected for raster coordinate number n (n clocks after reset release).
    function automatic pins_t model_pins(cfg_t c, int n, int unsigned s1, int unsigned s2);
        pins_t p;
        int ht, vt, x, y, col, rr, gg, bb;
        ht  = c.ha + c.hf + c.hsw + c.hb;
        vt  = c.va + c.vf + c.vsw + c.vb;
        x   = n % ht;
        y   = (n / ht) % vt;
        col = int'(pat(c.mode, x, y, s1, s2));
        rr  = col / 32;
        gg  = (col / 4) % 8;
        bb  = col % 4;
        p.hs = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hsw) ? c.sp : !c.sp;
        p.vs = (y >= c.va + c.vf && y < c.va + c.vf + c.vsw) ? c.sp : !c.sp;
        if (x < c.ha && y < c.va) begin
            p.r = 4'(rr * 2 + rr / 4);
            p.g = 4'(gg * 2 + gg / 4);
            p.b = 4'(bb * 5);
        end else begin
            p.r = 4'd0;
            p.g = 4'd0;
            p.b = 4'd0;
        end
        return p;
    endfunction

    function automatic pins_t reset_pins(cfg_t c);
        pins_t p;
        p.r  = 4'd0;
        p.g  = 4'd0;
        p.b  = 4'd0;
        p.hs = !c.sp;
        p.vs = !c.sp;
        return p;
    endfunction

    for (genvar gk = 0; gk < NCFG; gk++) begin : g_cfg
        localparam int   K      = gk;
        localparam cfg_t CFG    = cfg_of(gk);
        localparam int   HT     = CFG.ha + CFG.hf + CFG.hsw + CFG.hb;
        localparam int   VT     = CFG.va + CFG.vf + CFG.vsw + CFG.vb;
        localparam int   ML_IDX = (CFG.ml == 0) ? 0 : CFG.ml - 1;

        logic        rst_n;
        logic [7:0]  rgb_in;
        logic [10:0] px;
        logic [10:0] py;
        logic        act;
        logic        tick;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
        logic        hs;
        logic        vs;
        logic [7:0]  pipe [0:4];

        int unsigned s1;
        int unsigned s2;
        pins_t       exp_q [$];
        pins_t       e;
        bit          run  = 1'b0;
        bit          done = 1'b0;
        int          prod_n;
        int          mon_n;
        int          mx;
        int          my;
        int          n1;

        vga_frame_driver #(
            .H_ACTIVE (CFG.ha),  .H_FP (CFG.hf), .H_SYNC (CFG.hsw), .H_BP (CFG.hb),
            .V_ACTIVE (CFG.va),  .V_FP (CFG.vf), .V_SYNC (CFG.vsw), .V_BP (CFG.vb),
            .MUX_LAT  (CFG.ml),  .SYNC_POL (CFG.sp)
        ) dut (
            .clk           (clk),
            .resetN        (rst_n),
            .rgbIn         (rgb_in),
            .pixelX        (px),
            .pixelY        (py),
            .displayActive (act),
            .frameTick     (tick),
            .vgaR          (r),
            .vgaG          (g),
            .vgaB          (b),
            .vgaHS         (hs),
            .vgaVS         (vs)
        );

        // Mux model: colour for the requested coordinate, MUX_LAT clocks later.
        always @(posedge clk) begin
            pipe[0] <= pat(CFG.mode, int'(px), int'(py), s1, s2);
            for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
        end
        assign rgb_in = (CFG.ml == 0) ? pat(CFG.mode, int'(px), int'(py), s1, s2)
                                      : pipe[ML_IDX];

        // Producer: each elapsed coordinate queues the pins it must produce.
        always @(posedge clk) begin
            if (run) begin
                exp_q.push_back(model_pins(CFG, prod_n, s1, s2));
                prod_n++;
            end
        end

        // Monitor: every cycle compares counters directly and pins against the queue.
        always @(negedge clk) begin
            if (run) begin
                mx = mon_n % HT;
                my = (mon_n / HT) % VT;
                check("pixelX", K, mon_n, int'(px), mx);
                check("pixelY", K, mon_n, int'(py), my);
                check("displayActive", K, mon_n, int'(act), int'(mx < CFG.ha && my < CFG.va));
                check("frameTick", K, mon_n, int'(tick),
                      int'(mon_n > 0 && ((mon_n - 1) % (HT * VT)) == CFG.va * HT));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cfg%0d scoreboard empty at cycle %0d", K, mon_n);
                end else begin
                    e = exp_q.pop_front();
                    check("vgaR",  K, mon_n, int'(r),  int'(e.r));
                    check("vgaG",  K, mon_n, int'(g),  int'(e.g));
                    check("vgaB",  K, mon_n, int'(b),  int'(e.b));
                    check("vgaHS", K, mon_n, int'(hs), int'(e.hs));
                    check("vgaVS", K, mon_n, int'(vs), int'(e.vs));
                end
                mon_n++;
            end
        end

        initial begin
            s1    = $urandom | 32'h1;
            s2    = $urandom | 32'h1;
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("reset pixelX", K, -1, int'(px), 0);
            check("reset pixelY", K, -1, int'(py), 0);
            check("reset displayActive", K, -1, int'(act), 1);
            check("reset frameTick", K, -1, int'(tick), 0);
            check("reset vgaR", K, -1, int'(r), 0);
            check("reset vgaHS", K, -1, int'(hs), int'(!CFG.sp));
            check("reset vgaVS", K, -1, int'(vs), int'(!CFG.sp));

            for (int pass = 0; pass < 2; pass++) begin
                // Release just after an edge; the first ML+1 pin cycles hold reset values.
                rst_n  = 1'b1;
                prod_n = 0;
                mon_n  = 0;
                exp_q.delete();
                for (int i = 0; i <= CFG.ml; i++) exp_q.push_back(reset_pins(CFG));
                run = 1'b1;

                if (pass == 0)
                    n1 = (K == 0) ? 2 * HT + 300 : int'($urandom_range(3 * HT * VT, 2 * HT * VT));
                else
                    n1 = (K == 0) ? 2 * HT + 100 : 2 * HT * VT + 40;
                repeat (n1) @(posedge clk);
                #1;
                run = 1'b0;

                if (pass == 0) begin
                    // Mid-frame reset: outputs must reach reset values with no edge.
                    rst_n = 1'b0;
                    #1;
                    check("async reset pixelX", K, n1, int'(px), 0);
                    check("async reset pixelY", K, n1, int'(py), 0);
                    check("async reset vgaR", K, n1, int'(r), 0);
                    check("async reset vgaG", K, n1, int'(g), 0);
                    check("async reset vgaB", K, n1, int'(b), 0);
                    check("async reset vgaHS", K, n1, int'(hs), int'(!CFG.sp));
                    check("async reset vgaVS", K, n1, int'(vs), int'(!CFG.sp));
                    check("async reset frameTick", K, n1, int'(tick), 0);
                    repeat (2) @(posedge clk);
                    #1;
                end
            end
            done = 1'b1;
        end
    end

    initial begin
        int c;
        for (c = 0; c < 12000; c++) begin
            @(posedge clk);
            if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done &&
                g_cfg[3].done && g_cfg[4].done) break;
        end
        if (c >= 12000) begin
            total++;
            bad++;
            $display("FAIL timeout: stimulus did not complete within %0d clocks", c);
        end
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
